// File: rtl/pulse_gen_multi.sv
// Multi-channel programmable pulse generator with per-channel phase offset.
// Supports continuous and burst modes, and drives waveform outputs from the system clock.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; outputs low; settings are latched on start
// RUN   | counters advance while enable is high; waveform outputs active
// DONE  | one-cycle completion pulse after a burst, then back to IDLE
module pulse_gen_multi #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      mode,
    input  logic [WIDTH-1:0]          period,
    input  logic [WIDTH-1:0]          high_time,
    input  logic [CHANNELS*WIDTH-1:0] phase,
    input  logic [WIDTH-1:0]          burst,
    output logic [CHANNELS-1:0]       signal,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] high_q, high_d;
    logic [WIDTH-1:0] burst_q, burst_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] bcnt_q, bcnt_d;
    logic [WIDTH-1:0] pos_q [CHANNELS];
    logic [WIDTH-1:0] pos_d [CHANNELS];
    logic             cnt_wrap;

    // Starting position so that a channel lags channel 0 by its phase; out-of-range phase counts as 0.
    function automatic logic [WIDTH-1:0] pos_init(input logic [WIDTH-1:0] per,
                                                  input logic [WIDTH-1:0] ph);
        if ((ph == '0) || (ph >= per)) begin
            return '0;
        end
        return per - ph;
    endfunction

    assign cnt_wrap = (cnt_q == (period_q - WIDTH'(1)));

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        high_d   = high_q;
        burst_d  = burst_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        bcnt_d   = bcnt_q;
        for (int k = 0; k < CHANNELS; k++) begin
            pos_d[k] = pos_q[k];
        end

        case (state_q)
            S_IDLE: begin
                if (start && !stop && (period != '0)) begin
                    period_d = period;
                    high_d   = high_time;
                    burst_d  = (burst == '0) ? WIDTH'(1) : burst;
                    mode_d   = mode;
                    cnt_d    = '0;
                    bcnt_d   = '0;
                    for (int k = 0; k < CHANNELS; k++) begin
                        pos_d[k] = pos_init(period, phase[k*WIDTH +: WIDTH]);
                    end
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (enable) begin
                    cnt_d = cnt_wrap ? '0 : cnt_q + WIDTH'(1);
                    for (int k = 0; k < CHANNELS; k++) begin
                        pos_d[k] = (pos_q[k] == (period_q - WIDTH'(1))) ? '0 : pos_q[k] + WIDTH'(1);
                    end
                    if (cnt_wrap) begin
                        bcnt_d = bcnt_q + WIDTH'(1);
                        if (mode_q && (bcnt_q == (burst_q - WIDTH'(1)))) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            period_q <= '0;
            high_q   <= '0;
            burst_q  <= '0;
            mode_q   <= 1'b0;
            cnt_q    <= '0;
            bcnt_q   <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                pos_q[k] <= '0;
            end
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            high_q   <= high_d;
            burst_q  <= burst_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            bcnt_q   <= bcnt_d;
            for (int k = 0; k < CHANNELS; k++) begin
                pos_q[k] <= pos_d[k];
            end
        end
    end

    // Outputs decode only flop outputs, so the reset clears them without a clock.
    always_comb begin
        signal = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            signal[k] = (state_q == S_RUN) && (pos_q[k] < high_q);
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Directed testbench for pulse_gen_multi. Stimulus queues the expected {signal, busy, done}
// for each cycle, and a negedge monitor pops and compares each entry.
module tb_pulse_gen_multi;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 2;

    logic                      clock = 1'b0;
    logic                      reset_n;
    logic                      enable;
    logic                      start;
    logic                      stop;
    logic                      mode;
    logic [WIDTH-1:0]          period;
    logic [WIDTH-1:0]          high_time;
    logic [CHANNELS*WIDTH-1:0] phase;
    logic [WIDTH-1:0]          burst;
    logic [CHANNELS-1:0]       signal;
    logic                      busy;
    logic                      done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] exp_q [$];
    string      tag_q [$];

    pulse_gen_multi #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .enable    (enable),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .period    (period),
        .high_time (high_time),
        .phase     (phase),
        .burst     (burst),
        .signal    (signal),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    // Advance one clock edge, then queue the expected outputs for the cycle that follows it.
    task automatic cyc(input string tag, input logic [1:0] sig, input logic bsy, input logic dn);
        @(posedge clock);
        #1;
        exp_q.push_back({sig, bsy, dn});
        tag_q.push_back(tag);
    endtask

    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            logic [3:0] e;
            logic [3:0] a;
            string      t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = {signal, busy, done};
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got signal=%b busy=%b done=%b, expected signal=%b busy=%b done=%b",
                         t, a[3:2], a[1], a[0], e[3:2], e[1], e[0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; enable = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0;
        period = '0; high_time = '0; phase = '0; burst = '0;

        cyc("reset_hold0", 2'b00, 1'b0, 1'b0);
        cyc("reset_hold1", 2'b00, 1'b0, 1'b0);
        reset_n = 1'b1;
        cyc("idle_after_reset", 2'b00, 1'b0, 1'b0);

        // Continuous mode: period 4, high 2, ch1 phase 1. Expected ch0 is 1100 and ch1 is 0110.
        period = 8'd4; high_time = 8'd2; phase = {8'd1, 8'd0}; mode = 1'b0; start = 1'b1;
        cyc("cont_c0", 2'b01, 1'b1, 1'b0);
        start = 1'b0;
        cyc("cont_c1", 2'b11, 1'b1, 1'b0);
        cyc("cont_c2", 2'b10, 1'b1, 1'b0);
        cyc("cont_c3", 2'b00, 1'b1, 1'b0);
        // Start during RUN with new settings must not restart or change the waveform.
        start = 1'b1; period = 8'd7; high_time = 8'd0; phase = '0;
        cyc("cont_restart_ignored0", 2'b01, 1'b1, 1'b0);
        start = 1'b0;
        cyc("cont_c5", 2'b11, 1'b1, 1'b0);
        cyc("cont_c6", 2'b10, 1'b1, 1'b0);
        cyc("cont_c7", 2'b00, 1'b1, 1'b0);
        cyc("cont_c8", 2'b01, 1'b1, 1'b0);
        stop = 1'b1;
        cyc("cont_stop", 2'b00, 1'b0, 1'b0);
        stop = 1'b0;
        cyc("cont_idle", 2'b00, 1'b0, 1'b0);

        // Burst mode: period 3, high 1, burst 2, ch1 phase 2. Expected ch0 is 100100 and ch1 is 001001.
        period = 8'd3; high_time = 8'd1; phase = {8'd2, 8'd0}; burst = 8'd2; mode = 1'b1; start = 1'b1;
        cyc("burst_c0", 2'b01, 1'b1, 1'b0);
        start = 1'b0;
        cyc("burst_c1", 2'b00, 1'b1, 1'b0);
        cyc("burst_c2", 2'b10, 1'b1, 1'b0);
        cyc("burst_c3", 2'b01, 1'b1, 1'b0);
        cyc("burst_c4", 2'b00, 1'b1, 1'b0);
        cyc("burst_c5", 2'b10, 1'b1, 1'b0);
        cyc("burst_done", 2'b00, 1'b0, 1'b1);
        cyc("burst_idle0", 2'b00, 1'b0, 1'b0);
        cyc("burst_idle1", 2'b00, 1'b0, 1'b0);

        // Enable held low for 3 cycles at pos 3 of a period-5 burst. The period stretches by 3 cycles.
        period = 8'd5; high_time = 8'd3; phase = '0; burst = 8'd1; mode = 1'b1; start = 1'b1;
        cyc("en_p0", 2'b11, 1'b1, 1'b0);
        start = 1'b0;
        cyc("en_p1", 2'b11, 1'b1, 1'b0);
        cyc("en_p2", 2'b11, 1'b1, 1'b0);
        cyc("en_p3", 2'b00, 1'b1, 1'b0);
        enable = 1'b0;
        cyc("en_hold0", 2'b00, 1'b1, 1'b0);
        cyc("en_hold1", 2'b00, 1'b1, 1'b0);
        cyc("en_hold2", 2'b00, 1'b1, 1'b0);
        enable = 1'b1;
        cyc("en_p4", 2'b00, 1'b1, 1'b0);
        cyc("en_done", 2'b00, 1'b0, 1'b1);
        cyc("en_idle", 2'b00, 1'b0, 1'b0);

        // A start with period 0 is ignored.
        period = 8'd0; high_time = 8'd2; mode = 1'b0; start = 1'b1;
        cyc("period0_idle0", 2'b00, 1'b0, 1'b0);
        cyc("period0_idle1", 2'b00, 1'b0, 1'b0);
        start = 1'b0;

        // If high_time is at least the period, the outputs stay high constantly.
        period = 8'd4; high_time = 8'd6; phase = {8'd1, 8'd0}; mode = 1'b0; start = 1'b1;
        cyc("hi_sat0", 2'b11, 1'b1, 1'b0);
        start = 1'b0;
        cyc("hi_sat1", 2'b11, 1'b1, 1'b0);
        cyc("hi_sat2", 2'b11, 1'b1, 1'b0);
        cyc("hi_sat3", 2'b11, 1'b1, 1'b0);
        cyc("hi_sat4", 2'b11, 1'b1, 1'b0);
        stop = 1'b1;
        cyc("hi_sat_stop", 2'b00, 1'b0, 1'b0);
        stop = 1'b0;

        // A phase of 7 with period 4 counts as 0, so ch1 is aligned with ch0.
        period = 8'd4; high_time = 8'd2; phase = {8'd7, 8'd0}; mode = 1'b0; start = 1'b1;
        cyc("ph7_c0", 2'b11, 1'b1, 1'b0);
        start = 1'b0;
        cyc("ph7_c1", 2'b11, 1'b1, 1'b0);
        cyc("ph7_c2", 2'b00, 1'b1, 1'b0);
        cyc("ph7_c3", 2'b00, 1'b1, 1'b0);
        cyc("ph7_c4", 2'b11, 1'b1, 1'b0);
        stop = 1'b1;
        cyc("ph7_stop", 2'b00, 1'b0, 1'b0);
        stop = 1'b0;

        // Stop takes priority over burst completion on the same edge, so done never rises.
        period = 8'd2; high_time = 8'd1; phase = '0; burst = 8'd1; mode = 1'b1; start = 1'b1;
        cyc("sb_c0", 2'b11, 1'b1, 1'b0);
        start = 1'b0;
        cyc("sb_c1", 2'b00, 1'b1, 1'b0);
        stop = 1'b1;
        cyc("sb_stop_wins", 2'b00, 1'b0, 1'b0);
        stop = 1'b0;
        cyc("sb_no_done", 2'b00, 1'b0, 1'b0);

        // Async reset in the middle of RUN. The outputs must clear before any clock edge.
        period = 8'd4; high_time = 8'd2; phase = {8'd1, 8'd0}; mode = 1'b0; start = 1'b1;
        cyc("rst_run0", 2'b01, 1'b1, 1'b0);
        start = 1'b0;
        cyc("rst_run1", 2'b11, 1'b1, 1'b0);
        @(negedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({signal, busy, done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_reset: got signal=%b busy=%b done=%b, expected all 0", signal, busy, done);
        end
        cyc("rst_held", 2'b00, 1'b0, 1'b0);
        reset_n = 1'b1;
        cyc("rst_released_idle", 2'b00, 1'b0, 1'b0);

        @(negedge clock);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_gen_multi.md
# pulse_gen_multi

Parametrised multi-channel pulse generator: a programmable-period, programmable-duty, phase-offset waveform source with continuous and burst (one-shot) modes. It is the next-generation replacement for the fixed toggle-pattern pulse source in the Guia 09 sequential exercises. It drives stimulus and strobe lines for downstream counters and FSMs from the single system clock.

## Interface
- WIDTH, 8, bit width of period, high-time, phase, burst and internal counters
- CHANNELS, 2, number of independent phase-shifted output channels
- clock  in  1  system clock, all state updates on rising edge
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low
- enable  in  1  count enable; low freezes all counters and outputs
- start  in  1  begin generation (sampled in IDLE only)
- stop  in  1  synchronous abort
- mode  in  1  0 = continuous, 1 = burst
- period  in  WIDTH  wave period in clocks
- high_time  in  WIDTH  clocks high per period
- phase  in  CHANNELS*WIDTH  per-channel offset, channel k at bits [k*WIDTH +: WIDTH]
- burst  in  WIDTH  periods to emit in burst mode
- signal  out  CHANNELS  waveform outputs
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse at normal burst completion

## Operation
- States: IDLE, RUN, DONE. Reset: IDLE, all counters 0, signal=0, busy=0, done=0.
- IDLE: on edge with start=1, stop=0, period!=0 -> latch period, high_time, phase, burst, mode; cnt=0, per-channel pos_k = (period - phase_k) mod period; bcnt=0; go RUN. start with period==0 is ignored.
- Latched phase_k >= period is treated as 0. Latched burst==0 is treated as 1.
- RUN, enable=1: every edge pos_k = (pos_k==period-1) ? 0 : pos_k+1; cnt likewise; on cnt wrap (cnt==period-1), bcnt+1.
- RUN, enable=0: counters, state and outputs hold.
- signal[k] = (state==RUN) && (pos_k < high_time_latched); decoded from registers, no glitch between registered sources.
- high_time >= period -> channel constantly high in RUN; high_time==0 -> constantly low.
- Continuous mode: RUN runs until stop.
- Burst mode: on the edge where cnt wraps and bcnt==burst-1 -> DONE.
- DONE: signal=0, busy=0, done=1 for exactly one cycle, then IDLE unconditionally (enable ignored).
- stop=1 in RUN -> IDLE next edge, signal=0, no done. stop has priority over start and over burst completion on the same edge.
- start while RUN or DONE is ignored; input changes after latch do not affect the running waveform.
- Width arithmetic: all counters WIDTH bits, compare unsigned; no counter ever reaches period.

## Timing
- Latency start->first waveform cycle: 1 clock (cycle after the start edge shows pos_k initial values).
- Each period occupies exactly `period` enabled clocks; high phase exactly min(high_time, period) clocks.
- Channel k lags channel 0 by phase_k clocks.
- busy rises the cycle after the start edge and falls the cycle DONE or the stop-induced IDLE is entered.
- Burst total RUN length: burst*period enabled clocks, then one DONE cycle.
- reset_n low at any time: immediate IDLE and all outputs 0, independent of clock.

## Test plan
- Reset: hold reset_n=0 mid-RUN -> signal=00, busy=0, done=0 at once, no clock edge needed.
- Continuous, period=4, high_time=2, phase={ch1=1, ch0=0}: ch0 = 1100 repeating, ch1 = 0110 repeating; busy=1 throughout.
- Burst, period=3, high_time=1, burst=2: ch0 = 100100 over 6 cycles, then done=1 for one cycle, then IDLE with busy=0.
- enable dropped for 3 cycles mid-period (period=5, high_time=3): waveform stretched by exactly 3 cycles, levels held, period count unchanged.
- Boundaries: period=0 start -> stays IDLE; high_time=6, period=4 -> constant 1; phase=7, period=4 -> aligned with phase 0.
- stop and burst completion on same edge (period=2, burst=1) -> IDLE, done never asserted; start asserted during RUN -> no restart.
